// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the button debounce slice.
//   btn_state_e          : debounce FSM state encoding (3 bits)
//   DEF_*_CYCLES         : timing defaults for the 100 MHz board
//   BENCH_*              : short timings used when simulating
//   max_int()            : elaboration-time helper for counter sizing
// -----------------------------------------------------------------------------
package btn_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS_CHK = 3'd1,
        PRESSED   = 3'd2,
        HELD      = 3'd3,
        REL_CHK   = 3'd4
    } btn_state_e;

    // 100 MHz board: 10 ms debounce, 0.5 s long press, 0.1 s repeat.
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_LONG_CYCLES     = 50000000;
    localparam int DEF_REPEAT_CYCLES   = 10000000;

    localparam int BENCH_DEBOUNCE = 4;
    localparam int BENCH_LONG     = 10;
    localparam int BENCH_REPEAT   = 3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_debounce_if.sv
// -----------------------------------------------------------------------------
// button_debounce_if
// Groups the button pad input and the conditioned outputs.
//   btn_i     : raw pad level (asynchronous, bouncing)
//   btn_o     : debounced level
//   press_o   : one-cycle strobe on accepted press (and auto-repeat)
//   release_o : one-cycle strobe on accepted release
//   long_o    : one-cycle strobe when the hold reaches the long-press time
//   state_dbg : current debounce FSM state, for observation only
// Signalling: there is no valid/ready pair here. Every strobe is a single
// clk_i cycle wide, carries no payload and cannot be back-pressured; a consumer
// that misses a strobe has lost that event.
// Modports: master = the side that owns the pad and consumes events,
//           slave  = the debouncer.
// -----------------------------------------------------------------------------
interface button_debounce_if;
    import btn_pkg::*;

    logic       btn_i;
    logic       btn_o;
    logic       press_o;
    logic       release_o;
    logic       long_o;
    btn_state_e state_dbg;

    modport master (
        output btn_i,
        input  btn_o, press_o, release_o, long_o, state_dbg
    );

    modport slave (
        input  btn_i,
        output btn_o, press_o, release_o, long_o, state_dbg
    );
endinterface

// File: rtl/button_sync.sv
// -----------------------------------------------------------------------------
// button_sync
// N-flop synchroniser for an asynchronous pad input (N >= 2).
//   clk_i : destination clock
//   rst_i : asynchronous active-high reset, clears every stage to 0
//   d_i   : asynchronous input
//   q_o   : synchronised output (last stage)
// -----------------------------------------------------------------------------
module button_sync #(
    parameter int N = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [N-1:0] sync_q;
    logic [N-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[N-2:0], d_i};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[N-1];

endmodule

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
// Synchronises a mechanical button and filters contact bounce with a
// counter-based FSM. Produces a debounced level plus press, release and
// long-press strobes, all registered.
//   clk_i : system clock
//   rst_i : asynchronous active-high reset
//   bus   : button_debounce_if.slave (btn_i in; btn_o, press_o, release_o,
//           long_o, state_dbg out)
// Optional build macro BUTTON_AUTOREPEAT_EN: while HELD, press_o re-pulses
// every REPEAT_CYCLES clocks. Without it HELD is terminal until release and
// REPEAT_CYCLES only influences the hold counter width.
// -----------------------------------------------------------------------------
module button_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic              clk_i,
    input  logic              rst_i,
    button_debounce_if.slave  bus
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(max_int(LONG_CYCLES, REPEAT_CYCLES) + 1);

    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] L_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] H_MAX  = '1;
`ifdef BUTTON_AUTOREPEAT_EN
    localparam logic [HW-1:0] R_LAST = HW'(REPEAT_CYCLES - 1);
`endif

    logic s;

    button_sync #(.N(2)) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (bus.btn_i),
        .q_o   (s)
    );

    btn_state_e    state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          from_held_q, from_held_d;   // REL_CHK return target
    logic          btn_q, btn_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;

    always_comb begin
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        hcnt_d      = hcnt_q;
        from_held_d = from_held_q;
        btn_d       = btn_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;

        // dcnt leaves its check state on reaching D_LAST, so the increments
        // below never pass D_LAST and cannot wrap.
        case (state_q)
            IDLE: begin
                btn_d = 1'b0;
                if (s) begin
                    state_d = PRESS_CHK;
                    dcnt_d  = '0;
                end
            end
            PRESS_CHK: begin
                if (!s) begin
                    state_d = IDLE;
                end else if (dcnt_q == D_LAST) begin
                    state_d = PRESSED;
                    btn_d   = 1'b1;
                    press_d = 1'b1;
                    hcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            PRESSED: begin
                // A release candidate wins over the long transition and
                // leaves hcnt untouched so it resumes if the release bounces.
                if (!s) begin
                    state_d     = REL_CHK;
                    dcnt_d      = '0;
                    from_held_d = 1'b0;
                end else if (hcnt_q == L_LAST) begin
                    state_d = HELD;
                    long_d  = 1'b1;
`ifdef BUTTON_AUTOREPEAT_EN
                    hcnt_d  = '0;
`endif
                end else if (hcnt_q != H_MAX) begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!s) begin
                    state_d     = REL_CHK;
                    dcnt_d      = '0;
                    from_held_d = 1'b1;
                end
`ifdef BUTTON_AUTOREPEAT_EN
                else if (hcnt_q == R_LAST) begin
                    press_d = 1'b1;
                    hcnt_d  = '0;
                end else if (hcnt_q != H_MAX) begin
                    hcnt_d = hcnt_q + 1'b1;
                end
`endif
            end
            REL_CHK: begin
                if (s) begin
                    state_d = from_held_q ? HELD : PRESSED;
                end else if (dcnt_q == D_LAST) begin
                    state_d   = IDLE;
                    btn_d     = 1'b0;
                    release_d = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                btn_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            dcnt_q      <= '0;
            hcnt_q      <= '0;
            from_held_q <= 1'b0;
            btn_q       <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            hcnt_q      <= hcnt_d;
            from_held_q <= from_held_d;
            btn_q       <= btn_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
        end
    end

    assign bus.btn_o     = btn_q;
    assign bus.press_o   = press_q;
    assign bus.release_o = release_q;
    assign bus.long_o    = long_q;
    assign bus.state_dbg = state_q;

endmodule
